// File: rtl/exc_commit_sequencer.sv
// -----------------------------------------------------------------------------
// exc_commit_sequencer
//
// Write-back stage commit sequencer for exceptions, interrupts and ERET.
//
// When a trigger is accepted in IDLE, the WB context is captured. The block
// then holds flush for FLUSH_CYCLES cycles. Next it pulses the CP0 write
// strobes for exactly one COMMIT cycle. Finally it offers a redirect PC to
// fetch and holds it until the fetch stage accepts it.
//
// Every output is registered. Each output register is loaded from the
// next-state/next-context view, so the outputs line up with the state the
// FSM is actually in.
//
// Ports
//   clk, resetn           clock, asynchronous active-low reset
//   wb_*                  WB instruction info and exception-detect results
//   hw_int, cause_sw_ip   interrupt lines (hardware[5:0], software[1:0])
//   status_in             CP0 Status (IE=bit0, EXL=bit1, IM=bits15:8)
//   epc_in                current CP0 EPC (ERET target)
//   redirect_ready        fetch accepts the redirect
//   busy, flush           pipeline hold / kill
//   cp0_we_*              one-cycle CP0 write strobes (COMMIT only)
//   cp0_*_wdata/...       CP0 write data (latched, qualified by strobes)
//   redirect_valid/_pc    redirect request to IF-stage PC mux
// -----------------------------------------------------------------------------
module exc_commit_sequencer #(
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        wb_valid,
    input  logic [31:0] wb_pc,
    input  logic        wb_in_ds,
    input  logic        wb_exc_valid,
    input  logic [4:0]  wb_exc_code,
    input  logic        wb_badvaddr_valid,
    input  logic [31:0] wb_badvaddr,
    input  logic        wb_eret,
    input  logic [5:0]  hw_int,
    input  logic [31:0] status_in,
    input  logic [1:0]  cause_sw_ip,
    input  logic [31:0] epc_in,
    input  logic        redirect_ready,
    output logic        busy,
    output logic        flush,
    output logic        cp0_we_epc,
    output logic        cp0_we_badvaddr,
    output logic        cp0_we_cause,
    output logic        cp0_we_status,
    output logic [31:0] cp0_epc_wdata,
    output logic [31:0] cp0_badvaddr_wdata,
    output logic [4:0]  cp0_cause_excode,
    output logic        cp0_cause_bd,
    output logic        cp0_status_exl,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_FLUSH    = 2'd1,
        S_COMMIT   = 2'd2,
        S_REDIRECT = 2'd3
    } state_t;

    // Everything captured in the trigger cycle; nothing from WB is looked
    // at again until the sequencer is back in IDLE.
    typedef struct packed {
        logic        is_eret;
        logic [4:0]  excode;
        logic        bd;
        logic [31:0] epc;
        logic [31:0] badvaddr;
        logic        badvaddr_valid;
        logic        skip_epc;
        logic        exl_wdata;
        logic [31:0] target;
    } ctx_t;

    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

    state_t     state, state_nxt;
    logic [2:0] cnt, cnt_nxt;
    ctx_t       ctx, ctx_nxt, ctx_new;

    // -------------------------------------------------------------------------
    // Trigger decode
    // -------------------------------------------------------------------------
    logic       st_ie, st_exl;
    logic [7:0] int_lines;
    logic       int_req, take_exc, trigger;
    logic       unused_status;

    assign st_ie         = status_in[0];
    assign st_exl        = status_in[1];
    assign int_lines     = {hw_int, cause_sw_ip};
    assign int_req       = st_ie & ~st_exl & (|(status_in[15:8] & int_lines));
    assign take_exc      = int_req | wb_exc_valid;
    assign trigger       = wb_valid & (take_exc | wb_eret);
    assign unused_status = ^{status_in[31:16], status_in[7:2]};

    // The interrupt wins over a synchronous exception on the same instruction.
    // ERET only counts when nothing traps. The BadVAddr write is only kept
    // for a real address-error exception.
    always_comb begin
        ctx_new                = '0;
        ctx_new.is_eret        = ~take_exc;
        ctx_new.excode         = int_req ? 5'h00 : wb_exc_code;
        ctx_new.bd             = wb_in_ds;
        ctx_new.epc            = wb_in_ds ? (wb_pc - 32'd4) : wb_pc;
        ctx_new.badvaddr       = wb_badvaddr;
        ctx_new.badvaddr_valid = ~int_req & wb_exc_valid & wb_badvaddr_valid;
        ctx_new.skip_epc       = st_exl;
        ctx_new.exl_wdata      = take_exc;
        ctx_new.target         = take_exc ? EXC_VECTOR : epc_in;
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
            cnt   <= '0;
            ctx   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            ctx   <= ctx_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ctx_nxt   = ctx;
        unique case (state)
            S_IDLE: begin
                if (trigger) begin
                    state_nxt = S_FLUSH;
                    cnt_nxt   = FLUSH_INIT;
                    ctx_nxt   = ctx_new;
                end
            end
            S_FLUSH: begin
                if (cnt == 3'd0) state_nxt = S_COMMIT;
                else             cnt_nxt   = cnt - 3'd1;
            end
            S_COMMIT: begin
                state_nxt = S_REDIRECT;
            end
            S_REDIRECT: begin
                if (redirect_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Output decode (from next state, then registered below)
    // -------------------------------------------------------------------------
    logic busy_d, flush_d, commit_d, redirect_valid_d;
    logic we_epc_d, we_badvaddr_d, we_cause_d, we_status_d;

    always_comb begin
        busy_d           = (state_nxt != S_IDLE);
        flush_d          = (state_nxt == S_FLUSH);
        commit_d         = (state_nxt == S_COMMIT);
        redirect_valid_d = (state_nxt == S_REDIRECT);
        we_status_d      = commit_d;
        we_cause_d       = commit_d & ~ctx_nxt.is_eret;
        // If EXL was already set at the trigger, EPC and BD must stay intact.
        we_epc_d         = commit_d & ~ctx_nxt.is_eret & ~ctx_nxt.skip_epc;
        we_badvaddr_d    = commit_d & ~ctx_nxt.is_eret & ctx_nxt.badvaddr_valid;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            busy               <= 1'b0;
            flush              <= 1'b0;
            cp0_we_epc         <= 1'b0;
            cp0_we_badvaddr    <= 1'b0;
            cp0_we_cause       <= 1'b0;
            cp0_we_status      <= 1'b0;
            cp0_epc_wdata      <= '0;
            cp0_badvaddr_wdata <= '0;
            cp0_cause_excode   <= '0;
            cp0_cause_bd       <= 1'b0;
            cp0_status_exl     <= 1'b0;
            redirect_valid     <= 1'b0;
            redirect_pc        <= '0;
        end else begin
            busy               <= busy_d;
            flush              <= flush_d;
            cp0_we_epc         <= we_epc_d;
            cp0_we_badvaddr    <= we_badvaddr_d;
            cp0_we_cause       <= we_cause_d;
            cp0_we_status      <= we_status_d;
            cp0_epc_wdata      <= ctx_nxt.epc;
            cp0_badvaddr_wdata <= ctx_nxt.badvaddr;
            cp0_cause_excode   <= ctx_nxt.excode;
            cp0_cause_bd       <= ctx_nxt.bd & ~ctx_nxt.skip_epc;
            cp0_status_exl     <= ctx_nxt.exl_wdata;
            redirect_valid     <= redirect_valid_d;
            redirect_pc        <= ctx_nxt.target;
        end
    end

endmodule

// File: doc/exc_commit_sequencer.md
Name: exc_commit_sequencer

Overview:
- Multi-cycle controller in WB that sequences exception, interrupt and ERET commit.
- Decides whether the WB instruction traps, flushes the pipeline, and issues ordered CP0 write strobes (EPC, BadVAddr, Cause, Status).
- Then hands a redirect PC to fetch over a valid/ready handshake.
- Sits between the WB exception-detect logic, the CP0 register file and the IF-stage PC mux.

Parameters:
EXC_VECTOR, 32'hBFC00380, redirect target for all exceptions and interrupts
FLUSH_CYCLES, 2, cycles flush is held high (1..7)

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
wb_valid  in  1  valid instruction in WB
wb_pc  in  32  PC of WB instruction
wb_in_ds  in  1  WB instruction is in a branch delay slot
wb_exc_valid  in  1  synchronous exception detected on WB instruction
wb_exc_code  in  5  ExcCode of that exception
wb_badvaddr_valid  in  1  exception is an address error (BadVAddr to be written)
wb_badvaddr  in  32  faulting address
wb_eret  in  1  WB instruction is ERET
hw_int  in  6  hardware interrupt lines
status_in  in  32  CP0 Status (bit0 IE, bit1 EXL, bits15:8 IM)
cause_sw_ip  in  2  Cause.IP[1:0] software interrupt bits
epc_in  in  32  current CP0 EPC
redirect_ready  in  1  fetch accepts redirect
busy  out  1  sequencer not IDLE; upstream stages hold
flush  out  1  kill all in-flight instructions
cp0_we_epc  out  1  EPC write strobe
cp0_we_badvaddr  out  1  BadVAddr write strobe
cp0_we_cause  out  1  Cause ExcCode/BD write strobe
cp0_we_status  out  1  Status EXL write strobe
cp0_epc_wdata  out  32  EPC write data
cp0_badvaddr_wdata  out  32  BadVAddr write data
cp0_cause_excode  out  5  Cause.ExcCode write data
cp0_cause_bd  out  1  Cause.BD write data
cp0_status_exl  out  1  Status.EXL write data
redirect_valid  out  1  redirect request to fetch
redirect_pc  out  32  redirect target

Behaviour:

Reset:
- resetn low → state IDLE immediately; all outputs 0, all latched context 0. Applies mid-operation in any state.
- No write strobe or redirect may be issued after reset deasserts until a new trigger.

Trigger evaluation (IDLE only, when wb_valid=1):
- int_req = IE & !EXL & |(IM & {hw_int, cause_sw_ip}).
- Priority: int_req (ExcCode 0x00) > wb_exc_valid (wb_exc_code) > wb_eret.
- An interrupt overrides a simultaneous synchronous exception; ERET is ignored if any exception or interrupt is taken.
- Trigger cycle T latches:
  - kind (EXC or ERET), excode, bd = wb_in_ds.
  - epc = wb_in_ds ? wb_pc-4 : wb_pc (32-bit wrap).
  - badvaddr plus its valid bit (cleared for interrupts).
  - skip_epc = EXL at T.
  - target = EXC_VECTOR for EXC, epc_in for ERET.
- Inputs in states other than IDLE are ignored.

State machine (all outputs registered):
- IDLE: busy=0. On trigger → FLUSH, counter = FLUSH_CYCLES-1.
- FLUSH: busy=1, flush=1. Counter decrements; at 0 → COMMIT. flush is high in cycles T+1..T+FLUSH_CYCLES.
- COMMIT (exactly one cycle, strobes high only here):
  - EXC: cp0_we_cause=1 with latched excode/bd; cp0_we_status=1 with cp0_status_exl=1; cp0_we_epc=!skip_epc; cp0_we_badvaddr=badvaddr_valid.
  - When skip_epc=1, cp0_cause_bd is driven 0 and the CP0 file must not take BD (cp0_we_epc=0 is the qualifier).
  - ERET: only cp0_we_status=1 with cp0_status_exl=0.
  - → REDIRECT.
- REDIRECT: redirect_valid=1, redirect_pc=target, held stable until redirect_ready=1. The handshake cycle returns to IDLE, with busy and redirect_valid low next cycle.
- Minimum trigger-to-IDLE latency: FLUSH_CYCLES+3 cycles (redirect_ready high).
- Write-data outputs hold their latched values outside COMMIT; consumers qualify them with the strobes.
- Counter width: 3 bits.

Test Plan:
1. Overflow: wb_exc_code=0x0C, wb_pc=0xBFC01000, wb_in_ds=0, Status=0x0000FF01, redirect_ready=1 → flush at T+1,T+2. COMMIT at T+3 with epc 0xBFC01000, excode 0x0C, bd 0, exl 1, no BadVAddr write. redirect_pc 0xBFC00380 at T+4; IDLE at T+5.
2. Delay-slot load address error: wb_pc=0xBFC01004, wb_in_ds=1, code 0x04, badvaddr 0x00000003 → EPC 0xBFC01000, bd 1, we_badvaddr with 0x00000003.
3. Simultaneous: hw_int=6'b000001, IM bit10=1, IE=1, EXL=0, wb_exc_code=0x0C → excode 0x00, we_badvaddr 0.
4. EXL=1 with syscall 0x08 and hw_int active → interrupt ignored. Cause excode 0x08 written, we_epc=0, redirect 0xBFC00380.
5. ERET with epc_in=0xBFC00100, redirect_ready low 3 cycles → only we_status with exl 0. redirect_valid and redirect_pc 0xBFC00100 held stable for 4 cycles; IDLE after handshake.
6. resetn pulsed low during FLUSH and during REDIRECT → all outputs 0 asynchronously. No COMMIT strobe after release; a new trigger is accepted normally.
